mips_alu_sequencer: RTL and testbench
=====================================

Name: mips_alu_sequencer

Overview:
Multi-cycle controller that executes one ALU instruction at a time on the register-file + ALU datapath. It accepts a 32-bit MIPS instruction word over a valid/ready handshake and decodes R-type and immediate ALU ops. It then drives register read addresses, ALUop, MUXsel and the immediate operand, captures the ALU result, and writes it back to the register file. It sits between an instruction source (fetch stub or testbench) and the regfile/ALU datapath.

Parameters:
ALUOP_W, 4, width of ALUop bus
IMM_SEXT_MASK, 6'b001010, unused-for-decode documentation constant; immediate-extension rule is fixed in Behaviour (no runtime effect)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction word present
instr_ready  output  1  sequencer can accept instruction
instr  input  32  MIPS instruction word
read_reg1  output  5  to regfile read port 1 (rs)
read_reg2  output  5  to regfile read port 2 (rt)
write_reg  output  5  to regfile write address
write_data  output  32  to regfile write data
RegWrite  output  1  regfile write enable
ALUop  output  4  ALU operation select
MUXsel  output  1  ALU B select: 0 = read_data2, 1 = imm_out
imm_out  output  32  extended immediate to mux in1
ALUout  input  32  ALU result from datapath
ALUzero  input  1  ALU zero flag from datapath
done  output  1  one-cycle pulse: instruction retired
result  output  32  retired ALU result, held until next done
result_zero  output  1  retired zero flag, held until next done
illegal  output  1  one-cycle pulse: unsupported instruction dropped

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- States: IDLE, EXEC, WB. Reset → IDLE. All outputs 0 on reset (instr_ready = 1 once in IDLE after reset deasserts; during reset instr_ready = 0).
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr into internal register and go to EXEC. If decode is illegal, pulse illegal the next cycle, do not enter EXEC, stay IDLE.
- Decode, opcode = instr[31:26], funct = instr[5:0]:
  - opcode 0x00, funct 0x20/0x21 → add, ALUop 0010
  - funct 0x22/0x23 → sub, ALUop 0110
  - funct 0x24 → and, ALUop 0000
  - funct 0x25 → or, ALUop 0001
  - funct 0x27 → nor, ALUop 1100
  - funct 0x2A → slt, ALUop 0111
  - R-type: MUXsel = 0, dest = rd (instr[15:11]).
  - opcode 0x08/0x09 addi/addiu → 0010; 0x0A slti → 0111. These sign-extend imm16.
  - opcode 0x0C andi → 0000; 0x0D ori → 0001. These zero-extend imm16.
  - I-type: MUXsel = 1, dest = rt (instr[20:16]).
  - Any other opcode/funct → illegal.
- EXEC (1 cycle): read_reg1 = rs, read_reg2 = rt, ALUop, MUXsel and imm_out driven from the latched instruction. At the clock edge, ALUout and ALUzero are captured into result_q/zero_q. Go to WB.
- WB (1 cycle): write_reg = dest, write_data = result_q, RegWrite = 1 unless dest == 0 (then RegWrite = 0). done = 1, result = result_q, result_zero = zero_q. Go to IDLE.
- Throughput: 3 cycles per instruction (accept, EXEC, WB). instr_ready = 0 in EXEC and WB.
- Outside the stated states: RegWrite = 0 and done = 0. Datapath address/control outputs hold the last latched values (don't-care to the datapath).
- reset asserted in EXEC or WB: no write occurs in that cycle, RegWrite/done forced 0, next state IDLE, latched instruction discarded.
- instr_valid held with an illegal word: one illegal pulse per accepted beat, i.e. it re-pulses every cycle while valid stays high.

Test Plan:
- reset, then instr=0x00221820 (add $3,$1,$2), ALUout stub 0x00000007 → EXEC drives read_reg1=1, read_reg2=2, ALUop=0010, MUXsel=0. WB drives write_reg=3, write_data=0x7, RegWrite=1, done=1, result=0x7.
- instr=0x2024FFFF (addi $4,$1,-1) → imm_out=0xFFFFFFFF, MUXsel=1, ALUop=0010, write_reg=4.
- instr=0x34058000 (ori $5,$0,0x8000) → imm_out=0x00008000, ALUop=0001. Then instr=0x00220020 (add $0,…) → done=1, RegWrite stays 0.
- instr=0x8C220000 (lw) → illegal pulse 1 cycle, RegWrite never 1, instr_ready stays 1. Then 0x00221822 (sub) executes with ALUop=0110, ALUzero=1 → result_zero=1.
- Back-to-back valid held high with 3 add instructions → accepted every 3 cycles, 3 done pulses, instr_ready low in EXEC/WB.
- reset asserted during WB of add $3 → RegWrite=0 that cycle, all outputs 0, state IDLE next cycle; next instruction executes normally.

Source files
------------

// File: rtl/mips_alu_sequencer.sv
// mips_alu_sequencer: multi-cycle controller that runs one MIPS ALU instruction at a
// time on the register-file + ALU datapath (accept -> EXEC -> WB, 3 cycles each).
module mips_alu_sequencer #(
    parameter int          ALUOP_W       = 4,
    parameter logic [5:0]  IMM_SEXT_MASK = 6'b001010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [4:0]         read_reg1,
    output logic [4:0]         read_reg2,
    output logic [4:0]         write_reg,
    output logic [31:0]        write_data,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               MUXsel,
    output logic [31:0]        imm_out,
    input  logic [31:0]        ALUout,
    input  logic               ALUzero,
    output logic               done,
    output logic [31:0]        result,
    output logic               result_zero,
    output logic               illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Decoded view of the incoming instruction word
    logic               w_legal;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_muxsel;
    logic [31:0]        w_imm;
    logic [4:0]         w_dest;
    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic               w_accept;

    // Latched instruction fields and captured ALU result
    logic [4:0]         r_rs;
    logic [4:0]         r_rt;
    logic [4:0]         r_dest;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_muxsel;
    logic [31:0]        r_imm;
    logic [31:0]        r_result;
    logic               r_zero;
    logic [31:0]        r_retResult;
    logic               r_retZero;
    logic               r_illegal;

    // The extension mask is documentation only; the extension rule is fixed by opcode
    logic w_unusedMask;
    assign w_unusedMask = ^IMM_SEXT_MASK;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_accept = (r_state == IDLE) && instr_valid;

    // Decode the live instruction word into ALU control, operand select and destination
    always_comb begin
        w_legal  = 1'b0;
        w_aluop  = '0;
        w_muxsel = 1'b0;
        w_imm    = 32'd0;
        w_dest   = instr[15:11];
        case (w_opcode)
            6'h00: begin
                w_muxsel = 1'b0;
                w_dest   = instr[15:11];
                case (w_funct)
                    6'h20, 6'h21: begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b0010); end
                    6'h22, 6'h23: begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b0110); end
                    6'h24:        begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b0000); end
                    6'h25:        begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b0001); end
                    6'h27:        begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b1100); end
                    6'h2A:        begin w_legal = 1'b1; w_aluop = ALUOP_W'(4'b0111); end
                    default:      w_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                w_legal  = 1'b1;
                w_aluop  = ALUOP_W'(4'b0010);
                w_muxsel = 1'b1;
                w_imm    = {{16{instr[15]}}, instr[15:0]};
                w_dest   = instr[20:16];
            end
            6'h0A: begin
                w_legal  = 1'b1;
                w_aluop  = ALUOP_W'(4'b0111);
                w_muxsel = 1'b1;
                w_imm    = {{16{instr[15]}}, instr[15:0]};
                w_dest   = instr[20:16];
            end
            6'h0C: begin
                w_legal  = 1'b1;
                w_aluop  = ALUOP_W'(4'b0000);
                w_muxsel = 1'b1;
                w_imm    = {16'd0, instr[15:0]};
                w_dest   = instr[20:16];
            end
            6'h0D: begin
                w_legal  = 1'b1;
                w_aluop  = ALUOP_W'(4'b0001);
                w_muxsel = 1'b1;
                w_imm    = {16'd0, instr[15:0]};
                w_dest   = instr[20:16];
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State register; reset always returns to IDLE and abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake/write-back strobes; reset masks the strobes in its own cycle
    always_comb begin
        w_nextState = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        RegWrite    = 1'b0;
        result      = r_retResult;
        result_zero = r_retZero;
        case (r_state)
            IDLE: begin
                instr_ready = !reset;
                if (instr_valid && w_legal) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = WB;
            end
            WB: begin
                w_nextState = IDLE;
                done        = !reset;
                RegWrite    = !reset && (r_dest != 5'd0);
                result      = r_result;
                result_zero = r_zero;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latch fields on a legal accept, capture the ALU in EXEC, retire the result in WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs        <= 5'd0;
            r_rt        <= 5'd0;
            r_dest      <= 5'd0;
            r_aluop     <= '0;
            r_muxsel    <= 1'b0;
            r_imm       <= 32'd0;
            r_result    <= 32'd0;
            r_zero      <= 1'b0;
            r_retResult <= 32'd0;
            r_retZero   <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_rs     <= instr[25:21];
                r_rt     <= instr[20:16];
                r_dest   <= w_dest;
                r_aluop  <= w_aluop;
                r_muxsel <= w_muxsel;
                r_imm    <= w_imm;
            end
            if (r_state == EXEC) begin
                r_result <= ALUout;
                r_zero   <= ALUzero;
            end
            if (r_state == WB) begin
                r_retResult <= r_result;
                r_retZero   <= r_zero;
            end
        end
    end

    assign read_reg1  = r_rs;
    assign read_reg2  = r_rt;
    assign write_reg  = r_dest;
    assign write_data = r_result;
    assign ALUop      = r_aluop;
    assign MUXsel     = r_muxsel;
    assign imm_out    = r_imm;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// tb_mips_alu_sequencer: directed stimulus with a cycle-level reference model and
// hand-computed literal checks for the MIPS ALU sequencer.
module tb_mips_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        RegWrite;
    logic [3:0]  ALUop;
    logic        MUXsel;
    logic [31:0] imm_out;
    logic [31:0] ALUout;
    logic        ALUzero;
    logic        done;
    logic [31:0] result;
    logic        result_zero;
    logic        illegal;

    int nCompared   = 0;
    int nMismatched = 0;
    logic cmpEn = 1'b0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    mips_alu_sequencer #(.ALUOP_W(4), .IMM_SEXT_MASK(6'b001010)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .RegWrite    (RegWrite),
        .ALUop       (ALUop),
        .MUXsel      (MUXsel),
        .imm_out     (imm_out),
        .ALUout      (ALUout),
        .ALUzero     (ALUzero),
        .done        (done),
        .result      (result),
        .result_zero (result_zero),
        .illegal     (illegal)
    );

    typedef struct packed {
        logic        legal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [3:0]  aluop;
        logic        mux;
        logic [31:0] imm;
    } dec_t;

    // Instruction meaning straight from the MIPS encoding table
    function automatic dec_t decodeWord(input logic [31:0] w);
        dec_t d;
        logic [5:0] op;
        logic [5:0] fn;
        d    = '0;
        op   = w[31:26];
        fn   = w[5:0];
        d.rs = w[25:21];
        d.rt = w[20:16];
        if (op == 6'h00) begin
            d.dest = w[15:11];
            d.mux  = 1'b0;
            d.imm  = 32'd0;
            d.legal = 1'b1;
            if (fn == 6'h20 || fn == 6'h21)      d.aluop = 4'b0010;
            else if (fn == 6'h22 || fn == 6'h23) d.aluop = 4'b0110;
            else if (fn == 6'h24)                d.aluop = 4'b0000;
            else if (fn == 6'h25)                d.aluop = 4'b0001;
            else if (fn == 6'h27)                d.aluop = 4'b1100;
            else if (fn == 6'h2A)                d.aluop = 4'b0111;
            else                                 d.legal = 1'b0;
        end else begin
            d.dest  = w[20:16];
            d.mux   = 1'b1;
            d.legal = 1'b1;
            if (op == 6'h08 || op == 6'h09) begin
                d.aluop = 4'b0010; d.imm = {{16{w[15]}}, w[15:0]};
            end else if (op == 6'h0A) begin
                d.aluop = 4'b0111; d.imm = {{16{w[15]}}, w[15:0]};
            end else if (op == 6'h0C) begin
                d.aluop = 4'b0000; d.imm = {16'd0, w[15:0]};
            end else if (op == 6'h0D) begin
                d.aluop = 4'b0001; d.imm = {16'd0, w[15:0]};
            end else begin
                d.legal = 1'b0;
            end
        end
        return d;
    endfunction

    // Reference model: 0 = waiting, 1 = executing, 2 = writing back
    int          stage = 0;
    dec_t        cur   = '0;
    dec_t        mDec;
    logic [31:0] mResultQ   = 32'd0;
    logic [31:0] mRetResult = 32'd0;
    logic        mZeroQ     = 1'b0;
    logic        mRetZero   = 1'b0;
    logic        mIllegal   = 1'b0;

    // Advance the model on each rising edge from the same inputs the DUT sees
    always @(posedge clk) begin
        if (reset) begin
            stage = 0; cur = '0; mResultQ = 32'd0; mRetResult = 32'd0;
            mZeroQ = 1'b0; mRetZero = 1'b0; mIllegal = 1'b0;
        end else begin
            mIllegal = 1'b0;
            if (stage == 0) begin
                if (instr_valid) begin
                    mDec = decodeWord(instr);
                    if (mDec.legal) begin
                        cur   = mDec;
                        stage = 1;
                    end else begin
                        mIllegal = 1'b1;
                    end
                end
            end else if (stage == 1) begin
                mResultQ = ALUout;
                mZeroQ   = ALUzero;
                stage    = 2;
            end else begin
                mRetResult = mResultQ;
                mRetZero   = mZeroQ;
                stage      = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("instr_ready", 32'(instr_ready), 32'(stage == 0 && !reset));
            checkOutput("done",        32'(done),        32'(stage == 2 && !reset));
            checkOutput("RegWrite",    32'(RegWrite),    32'(stage == 2 && !reset && cur.dest != 5'd0));
            checkOutput("illegal",     32'(illegal),     32'(mIllegal));
            checkOutput("read_reg1",   32'(read_reg1),   32'(cur.rs));
            checkOutput("read_reg2",   32'(read_reg2),   32'(cur.rt));
            checkOutput("write_reg",   32'(write_reg),   32'(cur.dest));
            checkOutput("ALUop",       32'(ALUop),       32'(cur.aluop));
            checkOutput("MUXsel",      32'(MUXsel),      32'(cur.mux));
            checkOutput("imm_out",     imm_out,          cur.imm);
            checkOutput("write_data",  write_data,       mResultQ);
            checkOutput("result",      result,           (stage == 2) ? mResultQ : mRetResult);
            checkOutput("result_zero", 32'(result_zero), 32'((stage == 2) ? mZeroQ : mRetZero));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    // Present one instruction for a single accept edge; returns in the following cycle
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] aluRes, input logic aluZ);
        instr       = w;
        ALUout      = aluRes;
        ALUzero     = aluZ;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    int doneCount;
    int readyLow;

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        ALUout      = 32'd0;
        ALUzero     = 1'b0;

        step();
        cmpEn = 1'b1;
        atNeg();
        checkOutput("resetReady",  32'(instr_ready), 32'd0);
        checkOutput("resetResult", result,           32'd0);
        step();
        reset = 1'b0;
        atNeg();
        checkOutput("idleReady", 32'(instr_ready), 32'd1);

        // add $3,$1,$2
        applyStimulus(32'h00221820, 32'h00000007, 1'b0);
        atNeg();
        checkOutput("addRs",    32'(read_reg1), 32'd1);
        checkOutput("addRt",    32'(read_reg2), 32'd2);
        checkOutput("addOp",    32'(ALUop),     32'b0010);
        checkOutput("addMux",   32'(MUXsel),    32'd0);
        checkOutput("addReady", 32'(instr_ready), 32'd0);
        step();
        atNeg();
        checkOutput("addWreg",  32'(write_reg), 32'd3);
        checkOutput("addWdata", write_data,     32'h7);
        checkOutput("addRegW",  32'(RegWrite),  32'd1);
        checkOutput("addDone",  32'(done),      32'd1);
        checkOutput("addRes",   result,         32'h7);
        step();

        // addi $4,$1,-1
        applyStimulus(32'h2024FFFF, 32'h00000010, 1'b0);
        atNeg();
        checkOutput("addiImm", imm_out,        32'hFFFFFFFF);
        checkOutput("addiMux", 32'(MUXsel),    32'd1);
        checkOutput("addiOp",  32'(ALUop),     32'b0010);
        step();
        atNeg();
        checkOutput("addiWreg", 32'(write_reg), 32'd4);
        step();

        // ori $5,$0,0x8000
        applyStimulus(32'h34058000, 32'h00008000, 1'b0);
        atNeg();
        checkOutput("oriImm", imm_out,    32'h00008000);
        checkOutput("oriOp",  32'(ALUop), 32'b0001);
        step();
        step();

        // add $0,$1,$2: retires without a register write
        applyStimulus(32'h00220020, 32'h00000003, 1'b0);
        step();
        atNeg();
        checkOutput("r0Done",  32'(done),     32'd1);
        checkOutput("r0RegW",  32'(RegWrite), 32'd0);
        step();

        // lw is not supported: illegal pulses on every accepted beat
        instr       = 32'h8C220000;
        instr_valid = 1'b1;
        step();
        atNeg();
        checkOutput("lwIllegal1", 32'(illegal),     32'd1);
        checkOutput("lwReady",    32'(instr_ready), 32'd1);
        checkOutput("lwRegW",     32'(RegWrite),    32'd0);
        step();
        instr_valid = 1'b0;
        atNeg();
        checkOutput("lwIllegal2", 32'(illegal), 32'd1);
        step();
        atNeg();
        checkOutput("lwIllegal3", 32'(illegal), 32'd0);

        // sub $3,$1,$2 with a zero result
        applyStimulus(32'h00221822, 32'h00000000, 1'b1);
        atNeg();
        checkOutput("subOp", 32'(ALUop), 32'b0110);
        step();
        atNeg();
        checkOutput("subZero", 32'(result_zero), 32'd1);
        step();
        atNeg();
        checkOutput("subZeroHeld", 32'(result_zero), 32'd1);

        // Back-to-back adds with valid held high for three instruction slots
        doneCount   = 0;
        readyLow    = 0;
        instr       = 32'h00221820;
        instr_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            ALUout  = 32'(i * 16);
            ALUzero = 1'b0;
            step();
            atNeg();
            if (done) doneCount++;
            if (!instr_ready) readyLow++;
        end
        instr_valid = 1'b0;
        checkOutput("b2bDone",     32'(doneCount), 32'd3);
        checkOutput("b2bReadyLow", 32'(readyLow),  32'd6);
        step();

        // Reset hits the write-back of add $3
        applyStimulus(32'h00221820, 32'h00000055, 1'b0);
        step();
        reset = 1'b1;
        atNeg();
        checkOutput("rstWbRegW", 32'(RegWrite), 32'd0);
        checkOutput("rstWbDone", 32'(done),     32'd0);
        step();
        reset = 1'b0;
        atNeg();
        checkOutput("rstRs",     32'(read_reg1),   32'd0);
        checkOutput("rstWreg",   32'(write_reg),   32'd0);
        checkOutput("rstOp",     32'(ALUop),       32'd0);
        checkOutput("rstResult", result,           32'd0);
        checkOutput("rstReady",  32'(instr_ready), 32'd1);

        applyStimulus(32'h00221820, 32'h00000009, 1'b0);
        step();
        atNeg();
        checkOutput("postRstRes",  result,          32'h9);
        checkOutput("postRstRegW", 32'(RegWrite),   32'd1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
